// File: rtl/alu_wide_add_seq_pkg.sv
// Shared definitions for the wide ADD/ADDX sequencer: default Alu width and
// the sequencer state encoding.
package alu_wide_add_seq_pkg;

  localparam int unsigned BITS_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;  // waiting for start
  localparam logic [2:0] ST_LO   = 3'd1;  // a_lo + b_lo
  localparam logic [2:0] ST_LO_X = 3'd2;  // lo_sum + 1 (X carry-in)
  localparam logic [2:0] ST_HI   = 3'd3;  // a_hi + b_hi
  localparam logic [2:0] ST_HI_C = 3'd4;  // hi_sum + 1 (carry from low half)

endpackage

// File: rtl/alu_wide_add_seq.sv
// Word/long ADD and ADDX sequencer driving a shared bits-wide Alu that has no
// carry-in. Carries (X and low->high) are applied as extra +1 passes; flags
// are accumulated per half with 68000 semantics.
module alu_wide_add_seq
  import alu_wide_add_seq_pkg::*;
#(
  parameter int unsigned bits = BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              long_op,
  input  logic              use_x,
  input  logic              x_in,
  input  logic              z_in,
  input  logic [2*bits-1:0] a_in,
  input  logic [2*bits-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [2*bits-1:0] result,
  output logic              c_out,
  output logic              z_out,
  output logic              v_out,
  output logic              n_out,
  output logic [bits-1:0]   alu_a,
  output logic [bits-1:0]   alu_b,
  input  logic [bits-1:0]   alu_o,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              alu_n
);

  localparam logic [bits-1:0] ONE = {{(bits-1){1'b0}}, 1'b1};

  logic [2:0]        state_q,   state_d;
  logic [bits-1:0]   a_hi_q,    a_hi_d;
  logic [bits-1:0]   b_hi_q,    b_hi_d;
  logic [bits-1:0]   lo_sum_q,  lo_sum_d;
  logic              long_q,    long_d;
  logic              use_x_q,   use_x_d;
  logic              x_q,       x_d;
  logic              zin_q,     zin_d;
  logic              carry_q,   carry_d;
  logic              ovf_q,     ovf_d;
  logic [bits-1:0]   alu_a_q,   alu_a_d;
  logic [bits-1:0]   alu_b_q,   alu_b_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic [2*bits-1:0] result_q,  result_d;
  logic              c_q, c_d, z_q, z_d, v_q, v_d, n_q, n_d;

  logic fin, fin_long, fin_c, fin_v, fin_zero;

  // Next-state: one Alu pass per clock, finishing writes result and flags.
  // carry_q/ovf_q are reused per half: on entry to HI they still hold the
  // low-half carry that decides whether HI_C is needed.
  always_comb begin
    state_d  = state_q;
    a_hi_d   = a_hi_q;
    b_hi_d   = b_hi_q;
    lo_sum_d = lo_sum_q;
    long_d   = long_q;
    use_x_d  = use_x_q;
    x_d      = x_q;
    zin_d    = zin_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    fin      = 1'b0;
    fin_long = 1'b0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    fin_zero = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_hi_d  = a_in[2*bits-1:bits];
          b_hi_d  = b_in[2*bits-1:bits];
          long_d  = long_op;
          use_x_d = use_x;
          x_d     = x_in;
          zin_d   = z_in;
          alu_a_d = a_in[bits-1:0];
          alu_b_d = b_in[bits-1:0];
          busy_d  = 1'b1;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        lo_sum_d = alu_o;
        carry_d  = alu_c;
        ovf_d    = alu_v;
        if (use_x_q && x_q) begin
          alu_a_d = alu_o;
          alu_b_d = ONE;
          state_d = ST_LO_X;
        end else if (long_q) begin
          alu_a_d = a_hi_q;
          alu_b_d = b_hi_q;
          state_d = ST_HI;
        end else begin
          fin   = 1'b1;
          fin_c = alu_c;
          fin_v = alu_v;
        end
      end
      ST_LO_X: begin
        lo_sum_d = alu_o;
        carry_d  = carry_q | alu_c;
        ovf_d    = ovf_q ^ alu_v;
        if (long_q) begin
          alu_a_d = a_hi_q;
          alu_b_d = b_hi_q;
          state_d = ST_HI;
        end else begin
          fin   = 1'b1;
          fin_c = carry_q | alu_c;
          fin_v = ovf_q ^ alu_v;
        end
      end
      ST_HI: begin
        carry_d = alu_c;
        ovf_d   = alu_v;
        if (carry_q) begin
          alu_a_d = alu_o;
          alu_b_d = ONE;
          state_d = ST_HI_C;
        end else begin
          fin      = 1'b1;
          fin_long = 1'b1;
          fin_c    = alu_c;
          fin_v    = alu_v;
        end
      end
      ST_HI_C: begin
        fin      = 1'b1;
        fin_long = 1'b1;
        fin_c    = carry_q | alu_c;
        fin_v    = ovf_q ^ alu_v;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (fin) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      result_d = fin_long ? {alu_o, lo_sum_q} : {a_hi_q, alu_o};
      fin_zero = alu_z & (!fin_long || (lo_sum_q == '0));
      c_d      = fin_c;
      v_d      = fin_v;
      n_d      = alu_n;
      z_d      = use_x_q ? (zin_q & fin_zero) : fin_zero;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      lo_sum_q <= '0;
      long_q   <= 1'b0;
      use_x_q  <= 1'b0;
      x_q      <= 1'b0;
      zin_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_hi_q   <= a_hi_d;
      b_hi_q   <= b_hi_d;
      lo_sum_q <= lo_sum_d;
      long_q   <= long_d;
      use_x_q  <= use_x_d;
      x_q      <= x_d;
      zin_q    <= zin_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_q;
  assign z_out  = z_q;
  assign v_out  = v_q;
  assign n_out  = n_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_wide_add_seq.sv
// Self-checking bench for alu_wide_add_seq: a plain 16-bit adder stands in for
// the Alu, and expected results come from whole-width arithmetic.
module tb_alu_wide_add_seq;

  localparam int B = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, long_op = 1'b0, use_x = 1'b0, x_in = 1'b0, z_in = 1'b0;
  logic [31:0]   a_in = '0, b_in = '0;
  logic          busy, done, c_out, z_out, v_out, n_out;
  logic [31:0]   result;
  logic [B-1:0]  alu_a, alu_b, alu_o;
  logic          alu_c, alu_z, alu_v, alu_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Alu stand-in: combinational bits-wide add with flags
  assign {alu_c, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_z = (alu_o == '0);
  assign alu_n = alu_o[B-1];
  assign alu_v = (alu_a[B-1] == alu_b[B-1]) && (alu_o[B-1] != alu_a[B-1]);

  alu_wide_add_seq #(.bits(B)) dut (
    .clk(clk), .reset(reset), .start(start), .long_op(long_op), .use_x(use_x),
    .x_in(x_in), .z_in(z_in), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .c_out(c_out), .z_out(z_out), .v_out(v_out), .n_out(n_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_c(alu_c), .alu_z(alu_z),
    .alu_v(alu_v), .alu_n(alu_n)
  );

  typedef struct {
    logic [31:0] r;
    logic        c, z, v, n;
    int          passes;
  } exp_t;

  // Reference: the whole operation as one add of the active width plus X
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic lg,
                                 logic ux, logic x, logic z);
    exp_t e;
    logic [32:0] s;
    logic [16:0] lo;
    logic        cx;
    cx = ux & x;
    lo = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cx};
    if (lg) begin
      s = {1'b0, a} + {1'b0, b} + {32'd0, cx};
      e.r = s[31:0];
      e.c = s[32];
      e.v = (a[31] == b[31]) && (s[31] != a[31]);
      e.n = s[31];
      e.z = (s[31:0] == 32'd0) && (ux ? z : 1'b1);
      e.passes = 2 + int'(cx) + int'(lo[16]);
    end else begin
      e.r = {a[31:16], lo[15:0]};
      e.c = lo[16];
      e.v = (a[15] == b[15]) && (lo[15] != a[15]);
      e.n = lo[15];
      e.z = (lo[15:0] == 16'd0) && (ux ? z : 1'b1);
      e.passes = 1 + int'(cx);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation (inputs applied now, accepted at the next edge) and
  // leave time #1 after the done edge, so a following call is back to back.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic lg,
                        input logic ux, input logic x, input logic z, input logic poke);
    exp_t e;
    int   lat;
    logic got;
    e = model(a, b, lg, ux, x, z);
    a_in = a; b_in = b; long_op = lg; use_x = ux; x_in = x; z_in = z;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    if (poke) begin
      start = 1'b1;
      a_in = ~a;
      b_in = $urandom;
      long_op = ~lg;
    end
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(e.passes));
    check("result", result, e.r);
    check("c", 32'(c_out), 32'(e.c));
    check("z", 32'(z_out), 32'(e.z));
    check("v", 32'(v_out), 32'(e.v));
    check("n", 32'(n_out), 32'(e.n));
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          seen;

    // Reset state
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, c_out, z_out, v_out, n_out}, 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(32'h1234_7FFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_alu_a_hold", 32'(alu_a), 32'h7FFF);
    check("idle_alu_b_hold", 32'(alu_b), 32'h0001);

    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // start while busy is ignored
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized, back to back, with some carry-chain-biased operands
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) rb = (~ra) + 32'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) ra[15:0] = 16'hFFFF;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0));
    end

    // Reset asserted while in HI aborts without a done pulse
    a_in = 32'h0000_FFFF; b_in = 32'h0000_0001; long_op = 1'b1; use_x = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_alu_b", 32'(alu_b), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);

    run_op(32'h8000_FFFF, 32'h7FFF_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
